// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-access sequencer for the data memory.
// Misaligned halfword/word requests are answered with an error and never reach memory.
module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   input  logic [5:0]            req_func3,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_wr,
   output logic                  mem_read,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_func3,
   output logic [1:0]            mem_col,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          func3_q, func3_d;
   logic                id_q, id_d;
   logic                mis_q, mis_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                win_s;
   logic                accept_s;
   logic                sel_we_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic [2:0]          sel_func3_s;
   logic                sel_mis_s;

   // Arbitration, request select and alignment check
   always_comb begin
      win_s       = 1'b0;
      req_ready   = 2'b00;
      sel_mis_s   = 1'b0;
      case (req_valid)
         2'b01:   win_s = 1'b0;
         2'b10:   win_s = 1'b1;
         2'b11:   win_s = ~last_q;
         default: win_s = 1'b0;
      endcase
      accept_s = ((state_q == IDLE) || (state_q == RESP)) && (req_valid != 2'b00);
      if (accept_s) begin
         req_ready[win_s] = 1'b1;
      end else begin
         req_ready = 2'b00;
      end
      sel_we_s    = win_s ? req_we[1] : req_we[0];
      sel_addr_s  = win_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sel_wdata_s = win_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      sel_func3_s = win_s ? req_func3[5:3] : req_func3[2:0];
      case (sel_func3_s[1:0])
         2'b01:   sel_mis_s = sel_addr_s[0];
         2'b10:   sel_mis_s = (sel_addr_s[1:0] != 2'b00);
         default: sel_mis_s = 1'b0;
      endcase
   end

   // Next-state and request capture
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      func3_d = func3_q;
      id_d    = id_q;
      mis_d   = mis_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         ACCESS: begin
            state_d = RESP;
            rdata_d = we_q ? {DATA_W{1'b0}} : mem_rdata;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An accept in IDLE or RESP overrides the fall-back transitions above
      if (accept_s) begin
         last_d  = win_s;
         we_d    = sel_we_s;
         addr_d  = sel_addr_s;
         wdata_d = sel_wdata_s;
         func3_d = sel_func3_s;
         id_d    = win_s;
         mis_d   = sel_mis_s;
         rdata_d = {DATA_W{1'b0}};
         state_d = sel_mis_s ? RESP : ACCESS;
      end else begin
         last_d = last_q;
      end
   end

   // State and request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         func3_q <= 3'b000;
         id_q    <= 1'b0;
         mis_q   <= 1'b0;
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         func3_q <= func3_d;
         id_q    <= id_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory and response ports decode from state so reset silences them at once
   always_comb begin
      mem_wr    = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_func3 = 3'b000;
      mem_col   = 2'b00;
      rsp_valid = 2'b00;
      rsp_rdata = {DATA_W{1'b0}};
      rsp_err   = 1'b0;
      if (state_q == ACCESS) begin
         mem_wr    = we_q;
         mem_read  = ~we_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
         mem_func3 = func3_q;
         mem_col   = addr_q[1:0];
      end else begin
         mem_wr   = 1'b0;
         mem_read = 1'b0;
      end
      if (state_q == RESP) begin
         rsp_valid = id_q ? 2'b10 : 2'b01;
         rsp_rdata = rdata_q;
         rsp_err   = mis_q;
      end else begin
         rsp_valid = 2'b00;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single requests, a reset
// during a store, round-robin contention and a dropped request.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [5:0]  req_func3;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_wr;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_func3;
   logic [1:0]  mem_col;
   logic [31:0] mem_rdata;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_wr(mem_wr), .mem_read(mem_read), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_col(mem_col),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(logic [31:0] a);
      if (a == 32'h8) return 32'hDEADBEEF;
      else return (a * 32'h01000193) ^ 32'hC3C30F0F;
   endfunction

   always_comb mem_rdata = memfn(mem_addr);

   typedef struct { int cyc; logic [1:0] port; logic [31:0] rdata; logic err; } rsp_t;
   typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3; } mem_t;
   typedef struct { int port; logic we; logic [31:0] addr; logic [2:0] f3; logic [31:0] wdata; logic mis; } vec_t;

   rsp_t rsp_q[$];
   mem_t mem_q[$];
   int   gnt_port_q[$];
   int   gnt_cyc_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [1:0]  last_acc;
   logic        cur_we  [2];
   logic [31:0] cur_addr[2];
   logic [2:0]  cur_f3  [2];
   logic [31:0] cur_wd  [2];
   logic        cur_mis [2];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(int p, logic we, logic [31:0] a, logic [2:0] f3, logic [31:0] wd, logic mis);
      cur_we[p] = we; cur_addr[p] = a; cur_f3[p] = f3; cur_wd[p] = wd; cur_mis[p] = mis;
      req_we[p] = we;
      req_addr[p*32 +: 32] = a;
      req_func3[p*3 +: 3] = f3;
      req_wdata[p*32 +: 32] = wd;
   endtask

   // Called just after a falling edge with inputs already driven; samples, then advances one cycle.
   task automatic cycle();
      rsp_t r;
      mem_t m;
      #2;
      last_acc = req_valid & req_ready;
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (mem_q.size() != 0 && mem_q[0].cyc == cyc) begin
         m = mem_q.pop_front();
         chk("mem_wr", mem_wr, m.we);
         chk("mem_read", mem_read, !m.we);
         chk("mem_addr", mem_addr, m.addr);
         chk("mem_wdata", mem_wdata, m.wdata);
         chk("mem_func3", mem_func3, m.f3);
         chk("mem_col", mem_col, m.addr[1:0]);
      end else begin
         chk("mem_idle", {mem_wr, mem_read, mem_addr}, 64'd0);
      end
      if (rsp_valid != 2'b00) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 64'd0);
         end else begin
            r = rsp_q.pop_front();
            chk("rsp_cycle", cyc, r.cyc);
            chk("rsp_valid", rsp_valid, r.port);
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", rsp_err, r.err);
         end
      end else begin
         chk("rsp_idle", {rsp_err, rsp_rdata}, 64'd0);
         if (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
            r = rsp_q.pop_front();
            chk("rsp_missing_at", cyc, r.cyc);
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (last_acc[p]) begin
            gnt_port_q.push_back(p);
            gnt_cyc_q.push_back(cyc);
            r.cyc   = cyc + (cur_mis[p] ? 1 : 2);
            r.port  = (p == 0) ? 2'b01 : 2'b10;
            r.rdata = (cur_we[p] || cur_mis[p]) ? 32'h0 : memfn(cur_addr[p]);
            r.err   = cur_mis[p];
            rsp_q.push_back(r);
            if (!cur_mis[p]) begin
               m.cyc = cyc + 1; m.we = cur_we[p]; m.addr = cur_addr[p];
               m.wdata = cur_wd[p]; m.f3 = cur_f3[p];
               mem_q.push_back(m);
            end
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic issue(int p, logic we, logic [31:0] a, logic [2:0] f3, logic [31:0] wd, logic mis);
      set_req(p, we, a, f3, wd, mis);
      req_valid[p] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_acc[p]) break;
      end
      chk("accepted", last_acc[p], 64'd1);
      req_valid[p] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (rsp_q.size() != 0 || mem_q.size() != 0); i++) cycle();
      chk("drain", rsp_q.size() + mem_q.size(), 64'd0);
      rsp_q.delete();
      mem_q.delete();
      cycle();
      cycle();
   endtask

   task automatic chk_quiet(string tag);
      chk({tag, "_ready"}, req_ready, 64'd0);
      chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      chk({tag, "_mem"}, {mem_wr, mem_read, mem_col, mem_func3}, 64'd0);
      chk({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 64'd0);
   endtask

   vec_t vt[9];
   int   cnt[2];

   initial begin
      vt[0] = '{0, 1'b0, 32'h0000_0008, 3'b010, 32'h0,         1'b0};
      vt[1] = '{1, 1'b1, 32'h0000_0006, 3'b001, 32'h0000_1234, 1'b0};
      vt[2] = '{0, 1'b0, 32'h0000_0002, 3'b010, 32'h0,         1'b1};
      vt[3] = '{1, 1'b0, 32'h0000_0003, 3'b001, 32'h0,         1'b1};
      vt[4] = '{0, 1'b0, 32'h0000_0007, 3'b100, 32'h0,         1'b0};
      vt[5] = '{1, 1'b0, 32'h0000_0010, 3'b010, 32'h0,         1'b0};
      vt[6] = '{0, 1'b1, 32'h0000_0001, 3'b010, 32'h5555_AAAA, 1'b1};
      vt[7] = '{1, 1'b0, 32'h0000_000A, 3'b101, 32'h0,         1'b0};
      vt[8] = '{0, 1'b1, 32'h0000_00FF, 3'b000, 32'h0000_0077, 1'b0};

      rst = 1'b1;
      req_valid = 2'b00; req_we = 2'b00; req_addr = 64'd0; req_wdata = 64'd0; req_func3 = 6'd0;
      for (int p = 0; p < 2; p++) set_req(p, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk_quiet("reset");
      rst = 1'b0;
      @(negedge clk);
      cycle();

      // Table of single-port requests
      for (int i = 0; i < 9; i++) begin
         issue(vt[i].port, vt[i].we, vt[i].addr, vt[i].f3, vt[i].wdata, vt[i].mis);
         drain();
      end

      // Reset during the ACCESS cycle of a store
      issue(0, 1'b1, 32'h0000_0020, 3'b010, 32'hCAFE_F00D, 1'b0);
      #1;
      chk("pre_reset_mem_wr", mem_wr, 64'd1);
      rst = 1'b1;
      #1;
      chk_quiet("midreset");
      rsp_q.delete();
      mem_q.delete();
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      chk_quiet("postreset");
      @(negedge clk);
      repeat (3) cycle();

      // Contention: both ports stream 4 loads, first tie goes to port 0 after reset
      gnt_port_q.delete();
      gnt_cyc_q.delete();
      cnt[0] = 0; cnt[1] = 0;
      set_req(0, 1'b0, 32'h0000_0100, 3'b010, 32'h0, 1'b0);
      set_req(1, 1'b0, 32'h0000_0200, 3'b010, 32'h0, 1'b0);
      req_valid = 2'b11;
      for (int i = 0; i < 40 && (cnt[0] < 4 || cnt[1] < 4); i++) begin
         cycle();
         for (int p = 0; p < 2; p++) begin
            if (last_acc[p]) begin
               cnt[p]++;
               if (cnt[p] == 4) req_valid[p] = 1'b0;
               else set_req(p, 1'b0, 32'h100 * (p + 1) + 32'(cnt[p] * 4), 3'b010, 32'h0, 1'b0);
            end
         end
      end
      req_valid = 2'b00;
      drain();
      chk("gnt_count", gnt_port_q.size(), 64'd8);
      for (int i = 0; i < gnt_port_q.size(); i++) begin
         chk("gnt_order", gnt_port_q[i], 64'(i % 2));
         if (i > 0) chk("gnt_gap", gnt_cyc_q[i] - gnt_cyc_q[i-1], 64'd2);
      end

      // Request withdrawn while the arbiter is busy is dropped
      set_req(0, 1'b0, 32'h0000_0040, 3'b010, 32'h0, 1'b0);
      req_valid[0] = 1'b1;
      cycle();
      chk("drop_p0_acc", last_acc[0], 64'd1);
      req_valid[0] = 1'b0;
      set_req(1, 1'b0, 32'h0000_0044, 3'b010, 32'h0, 1'b0);
      req_valid[1] = 1'b1;
      #1;
      chk("drop_ready_busy", req_ready, 64'd0);
      cycle();
      req_valid[1] = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
